spi_frame_monitor: RTL

SPI_FRAME_MONITOR -- requirements
Module: spi_frame_monitor

---
 rtl/spi_frame_monitor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_monitor.sv
// Passive SPI frame snooper: checks length and XOR checksum of 4-byte frames,
// keeps saturating result counters and a small history FIFO of good frames.
module spi_frame_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             mosi,
    input  logic             clear_counters,
    input  logic             hist_rd_en,
    output logic             frame_active,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] csum_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [1:0]       last_err_code,
    output logic [23:0]      hist_data,
    output logic             hist_empty,
    output logic             hist_full,
    output logic             hist_overflow
);
    localparam int unsigned AW = $clog2(HIST_DEPTH);
    localparam int unsigned NW = AW + 1;

    typedef enum logic [1:0] {S_DISARMED, S_IDLE, S_RECV, S_OVERRUN} state_t;

    state_t           r_state;
    logic [31:0]      r_shift;
    logic [5:0]       r_bitcnt;
    logic             r_active;
    logic [CNT_W-1:0] r_ok_cnt;
    logic [CNT_W-1:0] r_csum_cnt;
    logic [CNT_W-1:0] r_len_cnt;
    logic [1:0]       r_code;
    logic             r_ovf;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [NW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic [23:0]      r_head;
    logic [23:0]      r_mem [HIST_DEPTH];

    logic             w_eval;
    logic [1:0]       w_code;
    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic [NW-1:0]    w_count_nxt;
    logic [AW-1:0]    w_rd_nxt;
    logic [23:0]      w_head_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Frame verdict; length errors mask the checksum check.
    always_comb begin
        w_eval = cs_n && ((r_state == S_RECV) || (r_state == S_OVERRUN));
        w_code = 2'b00;
        if (r_state == S_OVERRUN)
            w_code = 2'b11;
        else if (r_bitcnt < 6'd32)
            w_code = 2'b10;
        else if (r_shift[7:0] != (r_shift[31:24] ^ r_shift[23:16] ^ r_shift[15:8]))
            w_code = 2'b01;
    end

    // Push on full only succeeds when a pop frees a slot on the same edge.
    always_comb begin
        w_push      = w_eval && (w_code == 2'b00);
        w_pop       = hist_rd_en && !r_empty;
        w_wr        = w_push && (!r_full || w_pop);
        w_drop      = w_push && r_full && !w_pop;
        w_count_nxt = r_count + NW'(w_wr) - NW'(w_pop);
        w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        if (w_count_nxt == '0)
            w_head_nxt = 24'h0;
        else if (w_wr && (w_rd_nxt == r_wr_ptr))
            w_head_nxt = r_shift[31:8];
        else
            w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_DISARMED;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_active   <= 1'b0;
            r_ok_cnt   <= '0;
            r_csum_cnt <= '0;
            r_len_cnt  <= '0;
            r_code     <= 2'b00;
            r_ovf      <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_head     <= '0;
        end else begin
            case (r_state)
                S_DISARMED: begin
                    if (cs_n) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!cs_n) begin
                        r_state  <= S_RECV;
                        r_shift  <= {31'h0, mosi};
                        r_bitcnt <= 6'd1;
                        r_active <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (cs_n) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end else if (r_bitcnt == 6'd32) begin
                        r_state  <= S_OVERRUN;
                        r_bitcnt <= 6'd33;
                    end else begin
                        r_shift  <= {r_shift[30:0], mosi};
                        r_bitcnt <= r_bitcnt + 6'd1;
                    end
                end
                S_OVERRUN: begin
                    if (cs_n) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end else if (r_bitcnt != '1) begin
                        r_bitcnt <= r_bitcnt + 6'd1;
                    end
                end
                default: r_state <= S_DISARMED;
            endcase

            // Clear beats a same-edge frame result; the FIFO push is unaffected.
            if (clear_counters) begin
                r_ok_cnt   <= '0;
                r_csum_cnt <= '0;
                r_len_cnt  <= '0;
                r_code     <= 2'b00;
                r_ovf      <= 1'b0;
            end else begin
                if (w_eval) begin
                    r_code <= w_code;
                    case (w_code)
                        2'b00:   r_ok_cnt   <= sat_inc(r_ok_cnt);
                        2'b01:   r_csum_cnt <= sat_inc(r_csum_cnt);
                        default: r_len_cnt  <= sat_inc(r_len_cnt);
                    endcase
                end
                if (w_drop) r_ovf <= 1'b1;
            end

            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == NW'(HIST_DEPTH));
            r_head   <= w_head_nxt;
        end
    end

    always_ff @(posedge sclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift[31:8];
    end

    assign frame_active  = r_active;
    assign frame_ok_cnt  = r_ok_cnt;
    assign csum_err_cnt  = r_csum_cnt;
    assign len_err_cnt   = r_len_cnt;
    assign last_err_code = r_code;
    assign hist_data     = r_head;
    assign hist_empty    = r_empty;
    assign hist_full     = r_full;
    assign hist_overflow = r_ovf;

endmodule
